// File: rtl/gcd_core_if.sv
// Handshake bundle between the GPIO register block (master) and gcd_core (slave).
// last_cycles exists only when GCD_CYCLES_EN is defined.
`default_nettype none

interface gcd_core_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic [CNT_WIDTH-1:0] op_count;
`ifdef GCD_CYCLES_EN
  logic [CNT_WIDTH-1:0] last_cycles;

  modport master (output start, a_in, b_in,
                  input  busy, done, result, op_count, last_cycles);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, result, op_count, last_cycles);
`else
  modport master (output start, a_in, b_in,
                  input  busy, done, result, op_count);
  modport slave  (input  start, a_in, b_in,
                  output busy, done, result, op_count);
`endif
endinterface

`default_nettype wire

// File: rtl/gcd_core.sv
// gcd_core: iterative subtractive GCD engine with completed-operation counter.
// Optional GCD_CYCLES_EN adds last_cycles (CALC edges of the last op, saturating).
`default_nettype none

module gcd_core #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  wire logic   clk,
  input  wire logic   reset,
  gcd_core_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef GCD_CYCLES_EN
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] w_cyc_inc;

  assign w_cyc_inc = (cyc_q == {CNT_WIDTH{1'b1}}) ? cyc_q : cyc_q + C_CNT_ONE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
`ifdef GCD_CYCLES_EN
      cyc_q    <= '0;
      last_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
`ifdef GCD_CYCLES_EN
      cyc_q    <= cyc_d;
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cnt_d    = cnt_q;
`ifdef GCD_CYCLES_EN
    cyc_d    = cyc_q;
    last_d   = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.a_in == '0 || bus.b_in == '0) begin
            // gcd(x,0) = x and gcd(0,0) = 0, so OR yields the answer directly
            result_d = bus.a_in | bus.b_in;
            done_d   = 1'b1;
            cnt_d    = cnt_q + C_CNT_ONE;
`ifdef GCD_CYCLES_EN
            last_d   = '0;
`endif
          end else begin
            a_d     = bus.a_in;
            b_d     = bus.b_in;
            busy_d  = 1'b1;
            state_d = S_CALC;
`ifdef GCD_CYCLES_EN
            cyc_d   = '0;
`endif
          end
        end
      end
      S_CALC: begin
        if (a_q > b_q) begin
          a_d = a_q - b_q;
`ifdef GCD_CYCLES_EN
          cyc_d = w_cyc_inc;
`endif
        end else if (b_q > a_q) begin
          b_d = b_q - a_q;
`ifdef GCD_CYCLES_EN
          cyc_d = w_cyc_inc;
`endif
        end else begin
          result_d = a_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = cnt_q + C_CNT_ONE;
          state_d  = S_IDLE;
`ifdef GCD_CYCLES_EN
          // the compare edge itself counts as a CALC edge
          last_d   = w_cyc_inc;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.op_count = cnt_q;
`ifdef GCD_CYCLES_EN
  assign bus.last_cycles = last_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: Euclid-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a CNT_WIDTH=4 wrap instance.
`default_nettype none

module tb_gcd_core;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  gcd_core_if #(.WIDTH(32), .CNT_WIDTH(32)) bus ();
  gcd_core_if #(.WIDTH(32), .CNT_WIDTH(4))  bus2 ();

  gcd_core #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  gcd_core #(.WIDTH(32), .CNT_WIDTH(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // subtraction steps of the subtractive algorithm = sum of Euclid quotients - 1
  function automatic int f_subs(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    int s;
    s = 0;
    while (y != 0) begin
      s += int'(x / y);
      t = x % y;
      x = y;
      y = t;
    end
    return s - 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model, updated and compared after every edge
  int          k;
  logic        m_busy, m_done;
  logic [31:0] m_res, m_cnt, m_last, m_pres, m_plast;
  int          m_due;

  initial begin
    k = 0; m_busy = 0; m_done = 0; m_res = 0; m_cnt = 0; m_last = 0;
    m_pres = 0; m_plast = 0; m_due = 0;
  end

  always @(posedge clk) begin
    logic s, r;
    logic [31:0] a, b;
    s = bus.start; a = bus.a_in; b = bus.b_in; r = reset;
    #1;
    k++;
    if (r) begin
      m_busy = 0; m_done = 0; m_res = 0; m_cnt = 0; m_last = 0;
    end else begin
      m_done = 0;
      if (m_busy && k == m_due) begin
        m_done = 1; m_busy = 0; m_res = m_pres; m_cnt++; m_last = m_plast;
      end else if (!m_busy && s) begin
        if (a == 0 || b == 0) begin
          m_done = 1; m_res = a | b; m_cnt++; m_last = 0;
        end else begin
          m_busy  = 1;
          m_due   = k + f_subs(a, b) + 1;
          m_pres  = f_gcd(a, b);
          m_plast = 32'(f_subs(a, b) + 1);
        end
      end
    end
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("result", 64'(bus.result), 64'(m_res));
    chk("op_count", 64'(bus.op_count), 64'(m_cnt));
`ifdef GCD_CYCLES_EN
    chk("last_cycles", 64'(bus.last_cycles), 64'(m_last));
`endif
  end

  // ---------------- directed stimulus
  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic wait_done(input int max, output int edges);
    edges = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.done) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) chk("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic op2(input logic [31:0] a, input logic [31:0] b);
    int got;
    got = 0;
    @(negedge clk); bus2.start = 1'b1; bus2.a_in = a; bus2.b_in = b;
    @(negedge clk); bus2.start = 1'b0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      if (bus2.done) got = 1;
      else @(negedge clk);
    end
    if (got == 0) chk("wait_done2_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int e, nd, bad;
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    bus.start = 0;  bus.a_in = 0;  bus.b_in = 0;
    bus2.start = 0; bus2.a_in = 0; bus2.b_in = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("model_gcd_39_9", 64'(f_gcd(39, 9)), 64'd3);
    chk("model_subs_39_9", 64'(f_subs(39, 9)), 64'd6);
    chk("model_gcd_48_18", 64'(f_gcd(48, 18)), 64'd6);
    chk("reset_op_count", 64'(bus.op_count), 64'd0);
    chk("reset_result", 64'(bus.result), 64'd0);

    // 1: basic op with latency
    do_reset();
    bus.start = 1; bus.a_in = 39; bus.b_in = 9;
    @(negedge clk); bus.start = 0; bus.a_in = 0; bus.b_in = 0;
    chk("t1_busy_after_accept", 64'(bus.busy), 64'd1);
    wait_done(20, e);
    chk("t1_latency", 64'(e + 1), 64'd8);
    chk("t1_result", 64'(bus.result), 64'd3);
    chk("t1_op_count", 64'(bus.op_count), 64'd1);
`ifdef GCD_CYCLES_EN
    chk("t1_last_cycles", 64'(bus.last_cycles), 64'd7);
`endif

    // 2: 100 back-to-back ops, start held so each done cycle re-accepts
    do_reset();
    bus.start = 1; bus.a_in = 39; bus.b_in = 9;
    nd = 0; bad = 0;
    for (int c = 0; c < 1000 && nd < 100; c++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (bus.result != 3) bad++;
        if (nd == 100) bus.start = 0;
      end
    end
    bus.start = 0;
    chk("t2_done_pulses", 64'(nd), 64'd100);
    chk("t2_bad_results", 64'(bad), 64'd0);
    chk("t2_op_count", 64'(bus.op_count), 64'h64);

    // 3: zero-operand shortcut
    do_reset();
    bus.start = 1; bus.a_in = 0; bus.b_in = 12;
    @(negedge clk);
    chk("t3_done_1edge", 64'(bus.done), 64'd1);
    chk("t3_result", 64'(bus.result), 64'd12);
    chk("t3_busy", 64'(bus.busy), 64'd0);
    bus.a_in = 0; bus.b_in = 0;
    @(negedge clk); bus.start = 0;
    chk("t3_result_00", 64'(bus.result), 64'd0);
    chk("t3_op_count", 64'(bus.op_count), 64'd2);

    // 4: start while busy is ignored
    do_reset();
    bus.start = 1; bus.a_in = 48; bus.b_in = 18;
    @(negedge clk); bus.a_in = 7; bus.b_in = 5;
    @(negedge clk); bus.start = 0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("t4_done_count", 64'(nd), 64'd1);
    chk("t4_result", 64'(bus.result), 64'd6);
    chk("t4_op_count", 64'(bus.op_count), 64'd1);

    // 5: reset mid-CALC aborts, then a fresh op
    do_reset();
    bus.start = 1; bus.a_in = 1000; bus.b_in = 1;
    @(negedge clk); bus.start = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_busy_async", 64'(bus.busy), 64'd0);
    chk("t5_result_async", 64'(bus.result), 64'd0);
    chk("t5_op_count_async", 64'(bus.op_count), 64'd0);
    @(negedge clk); reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("t5_no_done", 64'(nd), 64'd0);
    bus.start = 1; bus.a_in = 21; bus.b_in = 14;
    @(negedge clk); bus.start = 0;
    wait_done(20, e);
    chk("t5_result", 64'(bus.result), 64'd7);
    chk("t5_op_count", 64'(bus.op_count), 64'd1);

    // 6: 4-bit counter wrap on second instance
    do_reset();
    for (int i = 0; i < 15; i++) op2(8, 4);
    chk("t6_count15", 64'(bus2.op_count), 64'd15);
    op2(8, 4);
    chk("t6_wrap", 64'(bus2.op_count), 64'd0);
    chk("t6_result", 64'(bus2.result), 64'd4);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
